// File: rtl/instr_pkg.sv
// Shared opcode field positions, status-flag indices and the decoded-instruction bundle
// used by the 6502 pre-decode queue.
package instr_pkg;

  localparam int unsigned AAA_MSB = 7;
  localparam int unsigned AAA_LSB = 5;
  localparam int unsigned BBB_MSB = 4;
  localparam int unsigned BBB_LSB = 2;
  localparam int unsigned CC_MSB  = 1;
  localparam int unsigned CC_LSB  = 0;

  localparam logic [1:0] CC_00 = 2'b00;
  localparam logic [1:0] CC_01 = 2'b01;
  localparam logic [1:0] CC_10 = 2'b10;
  localparam logic [1:0] CC_11 = 2'b11;

  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_V = 5;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic [6:0] FM_N    = 7'b1 << FLAG_N;
  localparam logic [6:0] FM_V    = 7'b1 << FLAG_V;
  localparam logic [6:0] FM_B    = 7'b1 << FLAG_B;
  localparam logic [6:0] FM_D    = 7'b1 << FLAG_D;
  localparam logic [6:0] FM_I    = 7'b1 << FLAG_I;
  localparam logic [6:0] FM_Z    = 7'b1 << FLAG_Z;
  localparam logic [6:0] FM_C    = 7'b1 << FLAG_C;
  localparam logic [6:0] FM_NZ   = FM_N | FM_Z;
  localparam logic [6:0] FM_NZC  = FM_NZ | FM_C;
  localparam logic [6:0] FM_NVZ  = FM_NZ | FM_V;
  localparam logic [6:0] FM_NVZC = FM_NVZ | FM_C;
  localparam logic [6:0] FM_ALL  = '1;

  typedef struct packed {
    logic [1:0] len;
    logic       sums;
    logic       ands;
    logic       ors;
    logic       eors;
    logic       srs;
    logic       dec_en;
    logic [6:0] flag_en;
    logic       illegal;
  } decode_t;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] b;
    b = op[BBB_MSB:BBB_LSB];
    op_len = 2'd2;
    case (op[CC_MSB:CC_LSB])
      CC_01: op_len = (b == 3'b011 || b == 3'b110 || b == 3'b111) ? 2'd3 : 2'd2;
      CC_10: begin
        if (b == 3'b011 || b == 3'b111)      op_len = 2'd3;
        else if (b == 3'b010 || b == 3'b110) op_len = 2'd1;
        else                                 op_len = 2'd2;
      end
      CC_00: begin
        if (op == 8'h20)                                   op_len = 2'd3;
        else if (op == 8'h00 || op == 8'h40 || op == 8'h60) op_len = 2'd1;
        else if (b == 3'b000)                              op_len = 2'd2;
        else if (b == 3'b010 || b == 3'b110)               op_len = 2'd1;
        else if (b == 3'b011 || b == 3'b111)               op_len = 2'd3;
        else                                               op_len = 2'd2;
      end
      default: op_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational 6502 opcode decoder: length, ALU select, decimal enable, flag-update
// enables and illegal-opcode detection.
module opcode_decode import instr_pkg::*; #(
  parameter int unsigned DECIMAL_EN   = 1,
  parameter int unsigned TRAP_ILLEGAL = 1
) (
  input  logic [7:0] i_opcode,
  output decode_t    o_dec
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;
  logic       w_illegal;
  decode_t    w_dec;

  assign w_aaa = i_opcode[AAA_MSB:AAA_LSB];
  assign w_bbb = i_opcode[BBB_MSB:BBB_LSB];
  assign w_cc  = i_opcode[CC_MSB:CC_LSB];

  assign w_illegal = (w_cc == CC_11) || (i_opcode == 8'h89) ||
                     (w_cc == CC_10 && w_bbb == 3'b000 && w_aaa != 3'b101) ||
                     (w_cc == CC_10 && w_bbb == 3'b100) ||
                     (i_opcode == 8'hDA) || (i_opcode == 8'hFA);

  always_comb begin
    w_dec     = '0;
    w_dec.len = op_len(i_opcode);
    case (w_cc)
      CC_01: begin
        case (w_aaa)
          3'd0: begin w_dec.ors  = 1'b1; w_dec.flag_en = FM_NZ; end
          3'd1: begin w_dec.ands = 1'b1; w_dec.flag_en = FM_NZ; end
          3'd2: begin w_dec.eors = 1'b1; w_dec.flag_en = FM_NZ; end
          3'd3: begin w_dec.sums = 1'b1; w_dec.dec_en = 1'b1; w_dec.flag_en = FM_NVZC; end
          3'd4: ;
          3'd5: w_dec.flag_en = FM_NZ;
          3'd6: begin w_dec.sums = 1'b1; w_dec.flag_en = FM_NZC; end
          default: begin w_dec.sums = 1'b1; w_dec.dec_en = 1'b1; w_dec.flag_en = FM_NVZC; end
        endcase
      end
      CC_10: begin
        // aaa 0..3 are ASL/ROL/LSR/ROR; aaa[1] picks the right-shifting pair
        if (!w_aaa[2]) begin
          if (w_bbb != 3'b110) begin
            w_dec.srs     = w_aaa[1];
            w_dec.flag_en = FM_NZC;
          end
        end else if (w_aaa == 3'd4) begin
          if (w_bbb == 3'b010) w_dec.flag_en = FM_NZ;
        end else if (w_aaa == 3'd5) begin
          w_dec.flag_en = FM_NZ;
        end else if (w_bbb[0] || (w_aaa == 3'd6 && w_bbb == 3'b010)) begin
          w_dec.sums    = 1'b1;
          w_dec.flag_en = FM_NZ;
        end
      end
      CC_00: begin
        case (i_opcode)
          8'h00:               w_dec.flag_en = FM_B | FM_I;
          8'h28, 8'h40:        w_dec.flag_en = FM_ALL;
          8'h18, 8'h38:        w_dec.flag_en = FM_C;
          8'h58, 8'h78:        w_dec.flag_en = FM_I;
          8'hB8:               w_dec.flag_en = FM_V;
          8'hD8, 8'hF8:        w_dec.flag_en = FM_D;
          8'h68, 8'h98, 8'hA8: w_dec.flag_en = FM_NZ;
          8'hA0, 8'hA4, 8'hAC, 8'hB4, 8'hBC: w_dec.flag_en = FM_NZ;
          8'h88, 8'hC8, 8'hE8: begin w_dec.sums = 1'b1; w_dec.flag_en = FM_NZ; end
          8'h24, 8'h2C:        begin w_dec.ands = 1'b1; w_dec.flag_en = FM_NVZ; end
          8'hC0, 8'hC4, 8'hCC, 8'hE0, 8'hE4, 8'hEC: begin
            w_dec.sums    = 1'b1;
            w_dec.flag_en = FM_NZC;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (w_illegal) begin
      w_dec         = '0;
      w_dec.len     = 2'd1;
      w_dec.illegal = (TRAP_ILLEGAL != 0);
    end
    if (DECIMAL_EN == 0) w_dec.dec_en = 1'b0;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/instr_predecode_queue.sv
// Assembles the fetched byte stream into whole 6502 instructions, decodes them at the
// opcode byte, and queues them toward execute with a valid/ready handshake.
module instr_predecode_queue import instr_pkg::*; #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned DECIMAL_EN   = 1,
  parameter int unsigned TRAP_ILLEGAL = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [7:0]  OPCODE,
  output logic [15:0] OPERAND,
  output logic [1:0]  LEN,
  output logic        SUMS,
  output logic        ANDS,
  output logic        ORS,
  output logic        EORS,
  output logic        SRS,
  output logic        DEC_EN,
  output logic [6:0]  FLAG_EN,
  output logic        ILLEGAL
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_OP, S_LO, S_HI} state_t;

  state_t        r_state, w_state_nx;
  logic [7:0]    r_op;
  logic [7:0]    r_lo;
  decode_t       r_dec;
  decode_t       w_dec;

  logic [7:0]    r_q_op      [DEPTH];
  logic [15:0]   r_q_operand [DEPTH];
  decode_t       r_q_dec     [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_valid, w_pop, w_acc, w_push;
  logic [7:0]    w_push_op;
  logic [15:0]   w_push_operand;
  decode_t       w_push_dec;
  decode_t       w_head_dec;

  opcode_decode #(
    .DECIMAL_EN   (DECIMAL_EN),
    .TRAP_ILLEGAL (TRAP_ILLEGAL)
  ) u_decode (
    .i_opcode (BYTE_IN),
    .o_dec    (w_dec)
  );

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & INSTR_READY;
  // Ready stays high during a flush so fetch never stalls; the byte itself is dropped.
  assign BYTE_READY = FLUSH | (r_count < DEPTH_C) | w_pop;
  assign w_acc      = BYTE_VALID & BYTE_READY & ~FLUSH;

  always_comb begin
    w_state_nx     = r_state;
    w_push         = 1'b0;
    w_push_op      = r_op;
    w_push_dec     = r_dec;
    w_push_operand = '0;
    if (w_acc) begin
      unique case (r_state)
        S_OP: begin
          w_push_op  = BYTE_IN;
          w_push_dec = w_dec;
          if (w_dec.len == 2'd1) w_push     = 1'b1;
          else                   w_state_nx = S_LO;
        end
        S_LO: begin
          if (r_dec.len == 2'd2) begin
            w_push         = 1'b1;
            w_push_operand = {8'h00, BYTE_IN};
            w_state_nx     = S_OP;
          end else begin
            w_state_nx = S_HI;
          end
        end
        S_HI: begin
          w_push         = 1'b1;
          w_push_operand = {BYTE_IN, r_lo};
          w_state_nx     = S_OP;
        end
        default: w_state_nx = S_OP;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_OP;
      r_op     <= '0;
      r_lo     <= '0;
      r_dec    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (FLUSH) begin
      r_state  <= S_OP;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_acc && r_state == S_OP) begin
        r_op  <= BYTE_IN;
        r_dec <= w_dec;
        r_lo  <= '0;
      end
      if (w_acc && r_state == S_LO) r_lo <= BYTE_IN;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_op[r_wr_ptr]      <= w_push_op;
      r_q_operand[r_wr_ptr] <= w_push_operand;
      r_q_dec[r_wr_ptr]     <= w_push_dec;
    end
  end

  assign w_head_dec  = w_valid ? r_q_dec[r_rd_ptr] : '0;
  assign INSTR_VALID = w_valid;
  assign OPCODE      = w_valid ? r_q_op[r_rd_ptr] : '0;
  assign OPERAND     = w_valid ? r_q_operand[r_rd_ptr] : '0;
  assign LEN         = w_head_dec.len;
  assign SUMS        = w_head_dec.sums;
  assign ANDS        = w_head_dec.ands;
  assign ORS         = w_head_dec.ors;
  assign EORS        = w_head_dec.eors;
  assign SRS         = w_head_dec.srs;
  assign DEC_EN      = w_head_dec.dec_en;
  assign FLAG_EN     = w_head_dec.flag_en;
  assign ILLEGAL     = w_head_dec.illegal;

endmodule
